fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  IF stage of the pipelined core: owns the program counter, drives the word address into
//  instr_mem (combinational read), and captures the returned instruction into the IF/ID register.
//  Handles stalls from hazard detection, redirects from EX (branch/jump), flushes (trap/redirect)
//  and misaligned redirect targets. Output feeds the decode stage.
// PARAMETERS
//  RESET_PC   0             PC value loaded on reset
// PORTS
//  clk            in   1               core clock; all state on posedge
//  rst            in   1               asynchronous, active-high reset
//  stall          in   1               hold PC and IF/ID (load-use hazard)
//  flush          in   1               replace IF/ID with bubble; PC unchanged unless redirect
//  redirect       in   1               load PC from redirect_pc (taken branch/jump in EX)
//  redirect_pc    in   `DataBusBits    redirect target byte address
//  imem_addr      out  `DataBusBits    = pc (combinational); instr_mem uses addr[13:2]
//  imem_instr     in   `InstrBusBits   instruction read for imem_addr, same cycle
//  id_pc          out  `DataBusBits    PC of instruction in IF/ID
//  id_pc_plus4    out  `DataBusBits    id_pc + 4 (link value)
//  id_instr       out  `InstrBusBits   instruction in IF/ID (`InstrNop when bubble)
//  id_valid       out  1               IF/ID holds a real slot
//  id_misaligned  out  1               slot is an instruction-address-misaligned exception
// BEHAVIOUR
//  - Reset (async, immediate): pc=RESET_PC, id_pc=0, id_pc_plus4=0, id_instr=`InstrNop,
//    id_valid=0, id_misaligned=0, mis_pend=0, mis_pc=0. First fetch at RESET_PC in first cycle after rst drops.
//  - Latency: instruction at pc appears on id_* one posedge after pc is presented (no stall).
//  - Posedge priority: redirect > flush > stall > normal.
//    redirect: pc<={redirect_pc[DataBusBits-1:2],2'b00}; IF/ID<=bubble (id_valid=0, id_instr=NOP,
//      id_misaligned=0); if redirect_pc[1:0]!=0 then mis_pend<=1, mis_pc<=redirect_pc, else mis_pend<=0.
//      Redirect overrides a simultaneous stall (stalled ID slot is wrong-path).
//    flush (no redirect): IF/ID<=bubble; pc holds; mis_pend<=0.
//    stall: pc, IF/ID, mis_pend, mis_pc all hold.
//    normal, mis_pend=0: pc<=pc+4; id_pc<=pc; id_pc_plus4<=pc+4; id_instr<=imem_instr; id_valid<=1.
//    normal, mis_pend=1: id_pc<=mis_pc; id_pc_plus4<=mis_pc+4; id_instr<=NOP; id_valid<=1;
//      id_misaligned<=1; mis_pend<=0; pc holds (trap redirect expected from downstream).
//  - Arithmetic: pc+4 in `DataBusBits, wraps modulo 2^DataBusBits; no bounds check vs imem depth.
//  - Bubble = id_valid 0 AND id_instr `InstrNop (addi x0,x0,0) so decode needs no valid gating.
//  - Reset asserted mid-stall/redirect: all state returns to reset values immediately.
// STRUCTURE
//  - diagv2_const.vh: add `InstrNop 32'h00000013; reuse `DataBusBits, `InstrBusBits.
//  - Sub-module if_id_reg: IF/ID register with hold (stall) and bubble (flush) controls;
//    fetch_stage keeps PC, next-PC mux and misalign tracking.
// TESTING
//  - Reset: rst=1 -> imem_addr=RESET_PC, id_valid=0, id_instr=0x00000013; release, 3 cycles with
//    imem returning 0xA,0xB,0xC -> id_pc=0,4,8, id_instr=0xA,0xB,0xC, id_valid=1.
//  - Stall: at pc=8 assert stall 2 cycles -> imem_addr stays 8, id_* unchanged; release -> pc=0xC.
//  - Redirect: redirect=1, redirect_pc=0x40 at pc=0x10 -> next cycle imem_addr=0x40, id_valid=0;
//    following cycle id_pc=0x40.
//  - Redirect+stall same cycle, redirect_pc=0x80 -> imem_addr=0x80, IF/ID bubble (redirect wins).
//  - Misaligned: redirect_pc=0x42 -> imem_addr=0x40, bubble; next edge id_pc=0x42, id_misaligned=1,
//    id_instr=NOP; flush instead of that edge -> mis_pend cleared, no misaligned slot produced.
//  - Async reset mid-operation (pc=0x24, id_valid=1) -> all outputs to reset values before next clk edge.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared widths, IF/ID slot payload and helpers for the fetch stage.
package fetch_stage_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned INSTR_W = 32;

    // addi x0,x0,0
    localparam logic [INSTR_W-1:0] INSTR_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [DATA_W-1:0]  pc;
        logic [DATA_W-1:0]  pc_plus4;
        logic [INSTR_W-1:0] instr;
        logic               valid;
        logic               misaligned;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{
        pc:         '0,
        pc_plus4:   '0,
        instr:      INSTR_NOP,
        valid:      1'b0,
        misaligned: 1'b0
    };

    function automatic logic [DATA_W-1:0] align_word(input logic [DATA_W-1:0] a);
        return {a[DATA_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: bubble insertion takes precedence over hold.
module fetch_stage_if_id_reg
    import fetch_stage_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   i_hold,
    input  logic   i_bubble,
    input  if_id_t i_d,
    output if_id_t o_q
);

    if_id_t r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= IF_ID_BUBBLE;
        end else if (i_bubble) begin
            r_q <= IF_ID_BUBBLE;
        end else if (!i_hold) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: program counter, next-PC selection, misaligned-redirect tracking and IF/ID register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [DATA_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               flush,
    input  logic               redirect,
    input  logic [DATA_W-1:0]  redirect_pc,
    output logic [DATA_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    output logic [DATA_W-1:0]  id_pc,
    output logic [DATA_W-1:0]  id_pc_plus4,
    output logic [INSTR_W-1:0] id_instr,
    output logic               id_valid,
    output logic               id_misaligned
);

    logic [DATA_W-1:0] r_pc;
    logic              r_mis_pend;
    logic [DATA_W-1:0] r_mis_pc;

    logic [DATA_W-1:0] w_pc_plus4;
    logic              w_redirect_mis;
    logic              w_bubble;
    if_id_t            w_slot;
    if_id_t            w_q;

    assign w_pc_plus4     = r_pc + DATA_W'(4);
    assign w_redirect_mis = |redirect_pc[1:0];
    assign w_bubble       = redirect | flush;

    // A pending misaligned target becomes an exception slot instead of a fetched instruction.
    always_comb begin
        w_slot.pc         = r_pc;
        w_slot.pc_plus4   = w_pc_plus4;
        w_slot.instr      = imem_instr;
        w_slot.valid      = 1'b1;
        w_slot.misaligned = 1'b0;
        if (r_mis_pend) begin
            w_slot.pc         = r_mis_pc;
            w_slot.pc_plus4   = r_mis_pc + DATA_W'(4);
            w_slot.instr      = INSTR_NOP;
            w_slot.misaligned = 1'b1;
        end
    end

    // PC holds while the misaligned slot is issued; downstream trap logic redirects it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_mis_pend <= 1'b0;
            r_mis_pc   <= '0;
        end else if (redirect) begin
            r_pc       <= align_word(redirect_pc);
            r_mis_pend <= w_redirect_mis;
            if (w_redirect_mis) begin
                r_mis_pc <= redirect_pc;
            end
        end else if (flush) begin
            r_mis_pend <= 1'b0;
        end else if (!stall) begin
            if (r_mis_pend) begin
                r_mis_pend <= 1'b0;
            end else begin
                r_pc <= w_pc_plus4;
            end
        end
    end

    fetch_stage_if_id_reg u_if_id_reg (
        .clk      (clk),
        .rst      (rst),
        .i_hold   (stall),
        .i_bubble (w_bubble),
        .i_d      (w_slot),
        .o_q      (w_q)
    );

    assign imem_addr     = r_pc;
    assign id_pc         = w_q.pc;
    assign id_pc_plus4   = w_q.pc_plus4;
    assign id_instr      = w_q.instr;
    assign id_valid      = w_q.valid;
    assign id_misaligned = w_q.misaligned;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed scoreboard bench for fetch_stage: behavioural model predicts each cycle's outputs.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        valid;
        logic        mis;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic [31:0] id_instr;
    logic        id_valid;
    logic        id_misaligned;

    int n_err = 0;
    int n_chk = 0;

    exp_t exp_q[$];

    logic [31:0] m_pc;
    logic        m_pend;
    logic [31:0] m_mpc;
    logic [31:0] m_idpc;
    logic [31:0] m_idpc4;
    logic [31:0] m_instr;
    logic        m_valid;
    logic        m_mis;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .imem_addr     (imem_addr),
        .imem_instr    (imem_instr),
        .id_pc         (id_pc),
        .id_pc_plus4   (id_pc_plus4),
        .id_instr      (id_instr),
        .id_valid      (id_valid),
        .id_misaligned (id_misaligned)
    );

    // Instruction memory: word at byte address a holds 0xA + a/4 (0xA, 0xB, 0xC, ...).
    function automatic logic [31:0] mem(input logic [31:0] a);
        return 32'hA + {2'b00, a[31:2]};
    endfunction

    assign imem_instr = mem(imem_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = 32'h0;
        m_pend  = 1'b0;
        m_mpc   = 32'h0;
        m_idpc  = 32'h0;
        m_idpc4 = 32'h0;
        m_instr = NOP;
        m_valid = 1'b0;
        m_mis   = 1'b0;
    endtask

    task automatic model_edge(input logic s, input logic f, input logic r, input logic [31:0] rpc);
        if (r) begin
            m_pc    = {rpc[31:2], 2'b00};
            m_valid = 1'b0;
            m_instr = NOP;
            m_mis   = 1'b0;
            m_pend  = (rpc[1:0] != 2'b00);
            if (m_pend) m_mpc = rpc;
        end else if (f) begin
            m_valid = 1'b0;
            m_instr = NOP;
            m_mis   = 1'b0;
            m_pend  = 1'b0;
        end else if (!s) begin
            if (m_pend) begin
                m_idpc  = m_mpc;
                m_idpc4 = m_mpc + 32'd4;
                m_instr = NOP;
                m_valid = 1'b1;
                m_mis   = 1'b1;
                m_pend  = 1'b0;
            end else begin
                m_idpc  = m_pc;
                m_idpc4 = m_pc + 32'd4;
                m_instr = mem(m_pc);
                m_valid = 1'b1;
                m_mis   = 1'b0;
                m_pc    = m_pc + 32'd4;
            end
        end
    endtask

    task automatic compare_outputs(input string tag, input exp_t e);
        chk({tag, ".imem_addr"}, imem_addr, e.addr);
        chk({tag, ".id_valid"}, 32'(id_valid), 32'(e.valid));
        chk({tag, ".id_instr"}, id_instr, e.instr);
        chk({tag, ".id_misaligned"}, 32'(id_misaligned), 32'(e.mis));
        if (e.valid) begin
            chk({tag, ".id_pc"}, id_pc, e.pc);
            chk({tag, ".id_pc_plus4"}, id_pc_plus4, e.pc4);
        end
    endtask

    // Entered at a negedge: drive, predict, clock once, compare, return at the next negedge.
    task automatic step(input string tag, input logic s, input logic f, input logic r,
                        input logic [31:0] rpc);
        exp_t e;
        stall       = s;
        flush       = f;
        redirect    = r;
        redirect_pc = rpc;
        model_edge(s, f, r, rpc);
        exp_q.push_back('{addr: m_pc, pc: m_idpc, pc4: m_idpc4, instr: m_instr,
                          valid: m_valid, mis: m_mis});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        compare_outputs(tag, e);
        @(negedge clk);
    endtask

    initial begin
        exp_t e;
        rst         = 1'b1;
        stall       = 1'b0;
        flush       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        model_reset();

        @(negedge clk);
        e = '{addr: 32'h0, pc: 32'h0, pc4: 32'h0, instr: NOP, valid: 1'b0, mis: 1'b0};
        compare_outputs("reset", e);
        chk("reset.id_pc_raw", id_pc, 32'h0);
        rst = 1'b0;

        step("fetch0", 1'b0, 1'b0, 1'b0, 32'h0);
        step("fetch1", 1'b0, 1'b0, 1'b0, 32'h0);
        step("stall0", 1'b1, 1'b0, 1'b0, 32'h0);
        step("stall1", 1'b1, 1'b0, 1'b0, 32'h0);
        step("fetch2", 1'b0, 1'b0, 1'b0, 32'h0);
        step("fetch3", 1'b0, 1'b0, 1'b0, 32'h0);

        step("redir40", 1'b0, 1'b0, 1'b1, 32'h0000_0040);
        step("after40", 1'b0, 1'b0, 1'b0, 32'h0);
        step("redir80_stall", 1'b1, 1'b0, 1'b1, 32'h0000_0080);
        step("after80", 1'b0, 1'b0, 1'b0, 32'h0);

        step("redir42", 1'b0, 1'b0, 1'b1, 32'h0000_0042);
        step("mis_slot", 1'b0, 1'b0, 1'b0, 32'h0);
        step("after_mis", 1'b0, 1'b0, 1'b0, 32'h0);

        step("redir106", 1'b0, 1'b0, 1'b1, 32'h0000_0106);
        step("mis_stall", 1'b1, 1'b0, 1'b0, 32'h0);
        step("mis_flush", 1'b0, 1'b1, 1'b0, 32'h0);
        step("after_flush", 1'b0, 1'b0, 1'b0, 32'h0);
        step("plain_flush", 1'b0, 1'b1, 1'b0, 32'h0);
        step("after_pflush", 1'b0, 1'b0, 1'b0, 32'h0);

        step("redir_top", 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        step("wrap", 1'b0, 1'b0, 1'b0, 32'h0);

        step("redir20", 1'b0, 1'b0, 1'b1, 32'h0000_0020);
        step("at24", 1'b0, 1'b0, 1'b0, 32'h0);

        // Asynchronous reset mid-cycle, while a stall is also asserted.
        stall = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        e = '{addr: 32'h0, pc: 32'h0, pc4: 32'h0, instr: NOP, valid: 1'b0, mis: 1'b0};
        compare_outputs("async_rst", e);
        chk("async_rst.id_pc_raw", id_pc, 32'h0);
        chk("async_rst.id_pc4_raw", id_pc_plus4, 32'h0);
        rst   = 1'b0;
        stall = 1'b0;
        #1;

        step("refetch0", 1'b0, 1'b0, 1'b0, 32'h0);
        step("refetch1", 1'b0, 1'b0, 1'b0, 32'h0);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
